// File: rtl/serial_subtractor_pkg.sv
// Shared encodings and sizing helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

  // Bit-counter width for a given operand width; never narrower than 1.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow generate/propagate.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: result = num1 - num2, LSB first, one bit per clock.
// Outputs are only updated when the last bit is produced, so partial
// differences are never visible.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out
);

  localparam int CW = cnt_width(WIDTH);

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             bout_q, bout_d;

  logic fs_d, fs_bout;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      bout_q   <= bout_d;
    end
  end

  // Next-state and datapath: accept in IDLE, one bit per RUN cycle, publish on last bit.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    bout_d   = bout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = num1;
          b_d      = num2;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        acc_d    = {fs_d, acc_q[WIDTH-1:1]};
        borrow_d = fs_bout;
        cnt_d    = cnt_q + CW'(1);
        // Last bit: the freshly completed acc goes straight to the outputs.
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d  = DONE;
          result_d = {fs_d, acc_q[WIDTH-1:1]};
          bout_d   = fs_bout;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign result     = result_q;
  assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] num1 = '0;
  logic [W-1:0] num2 = '0;
  logic         busy, done, borrow_out;
  logic [W-1:0] result;

  int n_vec = 0;
  int n_bad = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num1       (num1),
    .num2       (num2),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    return W'((int'(x) - int'(y)) & ((1 << W) - 1));
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

  // One operation from IDLE; optionally disturb operands/start during RUN.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit interfere);
    logic [W-1:0] old_r;
    logic         old_b;
    int           cyc, bcnt;
    old_r = result;
    old_b = borrow_out;
    @(negedge clk);
    num1  = x;
    num2  = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    bcnt  = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      chk("hold_result", result, old_r);
      chk("hold_borrow", borrow_out, old_b);
      if (interfere && cyc == 3) begin
        num1  = W'($urandom);
        num2  = W'($urandom);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", cyc - 1, W);
    chk("busy_cycles", bcnt, W);
    chk("busy_at_done", busy, 0);
    chk("result", result, ref_diff(x, y));
    chk("borrow_out", borrow_out, ref_borrow(x, y));
    @(negedge clk);
    chk("done_width", done, 0);
    chk("idle_busy", busy, 0);
    @(negedge clk);
    chk("no_reaccept", busy, 0);
  endtask

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           acc_cyc;
  } op_t;

  op_t q[$];

  initial begin
    int  cyc, ops, last_acc;
    bit  prev_busy, prev_done;
    op_t e;

    // Reset state
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_borrow", borrow_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed cases
    do_op(8'hCA, 8'h67, 0);
    chk("d_ca67", result, 8'h63);
    do_op(8'h2D, 8'hD2, 0);
    chk("d_2dd2_b", borrow_out, 1);
    do_op(8'h00, 8'h01, 0);
    chk("d_0001", result, 8'hFF);
    do_op(8'h00, 8'h00, 0);
    do_op(8'hFF, 8'hFF, 0);
    do_op(8'hCA, 8'h67, 0);
    do_op(8'hAA, 8'h55, 1);
    chk("d_aa55", result, 8'h55);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    num1  = 8'h37;
    num2  = 8'h12;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_result", result, 0);
    chk("arst_borrow", borrow_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("arst_no_done", done, 0);
    end
    do_op(8'h10, 8'h01, 0);
    chk("d_1001", result, 8'h0F);

    // Random sweep with start held high; operands change every cycle.
    @(negedge clk);
    start     = 1'b1;
    num1      = W'($urandom);
    num2      = W'($urandom);
    cyc       = 0;
    ops       = 0;
    last_acc  = -1;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    while (ops < 1000 && cyc < 20000) begin
      logic [W-1:0] dx, dy;
      dx = num1;
      dy = num2;
      @(negedge clk);
      cyc++;
      if (busy && !prev_busy) begin
        q.push_back('{x: dx, y: dy, acc_cyc: cyc});
        if (last_acc >= 0) chk("accept_spacing", cyc - last_acc, W + 2);
        last_acc = cyc;
      end
      if (done) begin
        chk("done_width_r", prev_done, 0);
        if (q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("latency_r", cyc - e.acc_cyc, W);
          chk("result_r", result, ref_diff(e.x, e.y));
          chk("borrow_r", borrow_out, ref_borrow(e.x, e.y));
          ops++;
        end
      end
      prev_busy = busy;
      prev_done = done;
      num1 = W'($urandom);
      num2 = W'($urandom);
    end
    if (ops < 1000) chk("sweep_timeout", ops, 1000);
    start = 1'b0;
    repeat (W + 3) @(negedge clk);
    chk("final_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
